ifsram_pd_gen: RTL and testbench

- Parametrised next-generation ifmap SRAM padding writer.
- After a start pulse it writes pad-value words into the edge ifmap SRAM buffers: left buffers 0..P-1, right buffers NUM_BUF-1..NUM_BUF-P.
- Supports a runtime pad width P up to MAX_PAD, a runtime kernel row count, a simultaneous left+right (BOTH) mode and a configurable pad value.
- Sits beside the ifmap SRAM write path; its cen/wen/addr/data are muxed into the buffer ports by the ifmap top.

---
 rtl/ifsram_pd_gen.sv | 206 ++++++++++++++++++++
 tb/tb_ifsram_pd_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifsram_pd_gen.sv
// ifsram_pd_gen: ifmap SRAM padding writer.
// After a start pulse, writes the pad value into the edge ifmap buffers:
// left buffers 0..P-1 and/or right buffers NUM_BUF-1..NUM_BUF-P. Column k
// covers (P-k)*atlchin words per kernel row. One word is written per cycle.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   if_pad_start        start request (sampled only in IDLE)
//   if_pad_busy/done    busy SETUP..DONE, one-cycle done pulse
//   cfg_*               run configuration, latched when start is accepted
//   pd_cen/pd_wen       per-buffer active-low enables (wen == cen)
//   pd_addr, pd_data    shared write address, latched pad value
module ifsram_pd_gen #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_BITS  = 11,
  parameter int unsigned NUM_BUF    = 8,
  parameter int unsigned MAX_PAD    = 3,
  parameter int unsigned MAX_ROWS   = 7,
  parameter int unsigned ATL_BITS   = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           if_pad_start,
  output logic                           if_pad_busy,
  output logic                           if_pad_done,
  input  logic [2:0]                     cfg_mast_state,
  input  logic [$clog2(MAX_PAD+1)-1:0]   cfg_pad_num,
  input  logic [$clog2(MAX_ROWS+1)-1:0]  cfg_row_num,
  input  logic [ATL_BITS-1:0]            cfg_atlchin,
  input  logic [MAX_ROWS*ADDR_BITS-1:0]  cfg_row_base,
  input  logic [DATA_WIDTH-1:0]          cfg_pad_value,
  output logic [NUM_BUF-1:0]             pd_cen,
  output logic [NUM_BUF-1:0]             pd_wen,
  output logic [ADDR_BITS-1:0]           pd_addr,
  output logic [DATA_WIDTH-1:0]          pd_data
);

  localparam int unsigned PAD_W = $clog2(MAX_PAD+1);
  localparam int unsigned ROW_W = $clog2(MAX_ROWS+1);
  localparam int unsigned COL_W = $clog2(2*MAX_PAD);
  localparam int unsigned WRD_W = ATL_BITS + PAD_W;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WRITE, S_DONE} state_t;

  state_t               state;
  logic [2:0]           mode_q;
  logic [PAD_W-1:0]     pad_q;
  logic [ROW_W-1:0]     rows_q;
  logic [ATL_BITS-1:0]  atl_q;
  logic [ADDR_BITS-1:0] base_q [MAX_ROWS];
  logic [COL_W-1:0]     col_q;
  logic [ROW_W-1:0]     row_q;
  logic [WRD_W-1:0]     word_q;

  // Column index c maps to {is_right, k}: in BOTH mode the right columns
  // follow the P left columns.
  function automatic logic [PAD_W:0] col_decode(input logic [COL_W-1:0] c,
                                                input logic [PAD_W-1:0] p,
                                                input logic right,
                                                input logic both);
    logic [COL_W-1:0] pc;
    pc = COL_W'(p);
    if (both && (c >= pc)) return {1'b1, PAD_W'(c - pc)};
    else                   return {right, PAD_W'(c)};
  endfunction

  logic                 is_left, is_right, is_both, no_work;
  logic                 cur_right, sel_right;
  logic [PAD_W-1:0]     cur_k, sel_k;
  logic [WRD_W-1:0]     cur_n, sel_off;
  logic [COL_W:0]       ncols;
  logic                 last_word, last_row, last_col, last_all;
  logic [COL_W-1:0]     nxt_col, sel_col;
  logic [ROW_W-1:0]     nxt_row, sel_row;
  logic [WRD_W-1:0]     nxt_word, sel_word;
  logic [ADDR_BITS-1:0] sel_base, addr_n;
  logic [NUM_BUF-1:0]   cen_n;
  int unsigned          bidx;

  always_comb begin
    is_left  = (mode_q == 3'd1) || (mode_q == 3'd7);
    is_right = (mode_q == 3'd3);
    is_both  = (mode_q == 3'd4);
    no_work  = (pad_q == '0) || (rows_q == '0) || (atl_q == '0) ||
               !(is_left || is_right || is_both);

    {cur_right, cur_k} = col_decode(col_q, pad_q, is_right, is_both);
    cur_n = WRD_W'(pad_q - cur_k) * WRD_W'(atl_q);
    ncols = is_both ? ((COL_W+1)'(pad_q) << 1) : (COL_W+1)'(pad_q);

    last_word = (word_q == cur_n - 1'b1);
    last_row  = (row_q == rows_q - 1'b1);
    last_col  = (((COL_W+1)'(col_q) + 1'b1) == ncols);
    last_all  = last_word && last_row && last_col;

    nxt_word = word_q + 1'b1;
    nxt_row  = row_q;
    nxt_col  = col_q;
    if (last_word) begin
      nxt_word = '0;
      nxt_row  = row_q + 1'b1;
      if (last_row) begin
        nxt_row = '0;
        nxt_col = col_q + 1'b1;
      end
    end

    // Outputs are registered one cycle ahead: SETUP presents the cleared
    // counters (first word), WRITE presents the following word.
    if (state == S_SETUP) begin
      sel_col  = col_q;
      sel_row  = row_q;
      sel_word = word_q;
    end else begin
      sel_col  = nxt_col;
      sel_row  = nxt_row;
      sel_word = nxt_word;
    end

    {sel_right, sel_k} = col_decode(sel_col, pad_q, is_right, is_both);
    sel_off = sel_right ? (WRD_W'(sel_k) * WRD_W'(atl_q)) : '0;

    sel_base = '0;
    for (int unsigned i = 0; i < MAX_ROWS; i++)
      if (sel_row == ROW_W'(i)) sel_base = base_q[i];
    addr_n = sel_base + ADDR_BITS'(sel_off) + ADDR_BITS'(sel_word);

    bidx = sel_right ? (NUM_BUF - 1 - 32'(sel_k)) : 32'(sel_k);
    cen_n = '1;
    for (int unsigned i = 0; i < NUM_BUF; i++)
      if (i == bidx) cen_n[i] = 1'b0;
  end

  assign pd_wen = pd_cen;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      if_pad_busy <= 1'b0;
      if_pad_done <= 1'b0;
      pd_cen      <= '1;
      pd_addr     <= '0;
      pd_data     <= '0;
      mode_q      <= '0;
      pad_q       <= '0;
      rows_q      <= '0;
      atl_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      word_q      <= '0;
      for (int unsigned i = 0; i < MAX_ROWS; i++) base_q[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if_pad_done <= 1'b0;
          pd_cen      <= '1;
          pd_addr     <= '0;
          if (if_pad_start) begin
            mode_q      <= cfg_mast_state;
            pad_q       <= cfg_pad_num;
            rows_q      <= cfg_row_num;
            atl_q       <= cfg_atlchin;
            pd_data     <= cfg_pad_value;
            for (int unsigned i = 0; i < MAX_ROWS; i++)
              base_q[i] <= cfg_row_base[i*ADDR_BITS +: ADDR_BITS];
            col_q       <= '0;
            row_q       <= '0;
            word_q      <= '0;
            if_pad_busy <= 1'b1;
            state       <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (no_work) begin
            if_pad_done <= 1'b1;
            state       <= S_DONE;
          end else begin
            pd_cen  <= cen_n;
            pd_addr <= addr_n;
            state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (last_all) begin
            pd_cen      <= '1;
            pd_addr     <= '0;
            if_pad_done <= 1'b1;
            state       <= S_DONE;
          end else begin
            col_q   <= nxt_col;
            row_q   <= nxt_row;
            word_q  <= nxt_word;
            pd_cen  <= cen_n;
            pd_addr <= addr_n;
          end
        end
        S_DONE: begin
          if_pad_done <= 1'b0;
          if_pad_busy <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifsram_pd_gen.sv
// Testbench for ifsram_pd_gen: stimulus task pushes the expected write
// stream into a scoreboard queue; a negedge monitor pops and compares each
// write the DUT presents. Timing of busy/done/write window is checked per
// cycle by the stimulus task.
module tb_ifsram_pd_gen;
  localparam int DW = 64, AB = 11, NB = 8, MP = 3, MR = 7, ATL = 5;

  logic clk = 1'b0;
  logic reset, if_pad_start, if_pad_busy, if_pad_done;
  logic [2:0]       cfg_mast_state;
  logic [1:0]       cfg_pad_num;
  logic [2:0]       cfg_row_num;
  logic [ATL-1:0]   cfg_atlchin;
  logic [MR*AB-1:0] cfg_row_base;
  logic [DW-1:0]    cfg_pad_value;
  logic [NB-1:0]    pd_cen, pd_wen;
  logic [AB-1:0]    pd_addr;
  logic [DW-1:0]    pd_data;

  always #5 clk = ~clk;

  ifsram_pd_gen #(
    .DATA_WIDTH(DW), .ADDR_BITS(AB), .NUM_BUF(NB),
    .MAX_PAD(MP), .MAX_ROWS(MR), .ATL_BITS(ATL)
  ) dut (
    .clk(clk), .reset(reset), .if_pad_start(if_pad_start),
    .if_pad_busy(if_pad_busy), .if_pad_done(if_pad_done),
    .cfg_mast_state(cfg_mast_state), .cfg_pad_num(cfg_pad_num),
    .cfg_row_num(cfg_row_num), .cfg_atlchin(cfg_atlchin),
    .cfg_row_base(cfg_row_base), .cfg_pad_value(cfg_pad_value),
    .pd_cen(pd_cen), .pd_wen(pd_wen), .pd_addr(pd_addr), .pd_data(pd_data)
  );

  typedef struct {
    logic [NB-1:0] cen;
    logic [AB-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t sb[$];
  wr_t mon_e;
  int  vectors = 0, miscompares = 0;
  bit  mon_en = 0;

  // Run configuration
  logic [2:0]    m_mode;
  int            m_p, m_r, m_atl;
  int            m_base [MR];
  logic [DW-1:0] m_pv;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (pd_cen !== '1) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got cen %b addr %0d, expected no write (t=%0t)",
                   pd_cen, pd_addr, $time);
        end else begin
          mon_e = sb.pop_front();
          check("cen",  64'(pd_cen),  64'(mon_e.cen));
          check("wen",  64'(pd_wen),  64'(mon_e.cen));
          check("addr", 64'(pd_addr), 64'(mon_e.addr));
          check("data", pd_data, mon_e.data);
        end
      end else begin
        check("idle_addr", 64'(pd_addr), 64'd0);
        check("idle_wen",  64'(pd_wen),  64'hFF);
      end
    end
  end

  // Reference model: enumerate writes straight from the column/row/word rules.
  task automatic model(input int limit, output int total);
    bit side_on [2];
    int cnt = 0;
    side_on[0] = (m_mode == 3'd1 || m_mode == 3'd7 || m_mode == 3'd4);
    side_on[1] = (m_mode == 3'd3 || m_mode == 3'd4);
    if (m_p == 0 || m_r == 0 || m_atl == 0) begin
      side_on[0] = 0;
      side_on[1] = 0;
    end
    for (int s = 0; s < 2; s++) begin
      if (side_on[s]) begin
        for (int k = 0; k < m_p; k++) begin
          int b = (s == 1) ? NB - 1 - k : k;
          int n = (m_p - k) * m_atl;
          int off = (s == 1) ? k * m_atl : 0;
          for (int r = 0; r < m_r; r++) begin
            for (int w = 0; w < n; w++) begin
              wr_t e;
              e.cen  = ~(NB'(1) << b);
              e.addr = AB'((m_base[r] + off + w) % 2048);
              e.data = m_pv;
              if (cnt < limit) sb.push_back(e);
              cnt++;
            end
          end
        end
      end
    end
    total = cnt;
  endtask

  task automatic scramble_cfg();
    cfg_mast_state = 3'($urandom);
    cfg_pad_num    = 2'($urandom);
    cfg_row_num    = 3'($urandom);
    cfg_atlchin    = ATL'($urandom);
    for (int i = 0; i < MR; i++) cfg_row_base[i*AB +: AB] = AB'($urandom);
    cfg_pad_value  = {$urandom, $urandom};
  endtask

  // rst_at > 0: assert reset during that cycle of the run.
  // spam: keep start high while busy and in DONE.
  task automatic run(input int rst_at, input bit spam);
    int nw, done_k;
    @(negedge clk);
    cfg_mast_state = m_mode;
    cfg_pad_num    = 2'(m_p);
    cfg_row_num    = 3'(m_r);
    cfg_atlchin    = ATL'(m_atl);
    for (int i = 0; i < MR; i++) cfg_row_base[i*AB +: AB] = AB'(m_base[i]);
    cfg_pad_value  = m_pv;
    if_pad_start   = 1'b1;
    model((rst_at > 0) ? rst_at - 1 : 1 << 30, nw);
    done_k = 2 + nw;
    for (int k = 1; k <= done_k + 1; k++) begin
      @(negedge clk);
      if (k == 1) scramble_cfg();
      if_pad_start = spam && (k <= done_k);
      if (rst_at > 0 && k >= rst_at) begin
        if (k == rst_at) reset = 1'b1;
        if (k == rst_at + 1) reset = 1'b0;
        if (k > rst_at) begin
          check("rst_busy", 64'(if_pad_busy), 64'd0);
          check("rst_done", 64'(if_pad_done), 64'd0);
          check("rst_cen",  64'(pd_cen), 64'hFF);
        end
        if (k == rst_at) begin
          check("busy", 64'(if_pad_busy), 64'd1);
          check("wr_active", 64'(pd_cen != '1), 64'(k >= 2 && k < 2 + nw));
        end
      end else begin
        check("busy", 64'(if_pad_busy), 64'(k <= done_k));
        check("done", 64'(if_pad_done), 64'(k == done_k));
        check("wr_active", 64'(pd_cen != '1), 64'(k >= 2 && k < 2 + nw));
      end
    end
    check("leftover", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int modes [8];
    modes = '{1, 2, 3, 4, 7, 0, 5, 6};
    reset = 1'b1;
    if_pad_start = 1'b0;
    scramble_cfg();
    repeat (3) @(negedge clk);
    check("rst_busy0", 64'(if_pad_busy), 64'd0);
    check("rst_done0", 64'(if_pad_done), 64'd0);
    check("rst_cen0",  64'(pd_cen), 64'hFF);
    check("rst_wen0",  64'(pd_wen), 64'hFF);
    check("rst_addr0", 64'(pd_addr), 64'd0);
    check("rst_data0", pd_data, 64'd0);
    reset = 1'b0;
    mon_en = 1;

    // LEFT P=2 R=5 atl=4
    m_mode = 3'd1; m_p = 2; m_r = 5; m_atl = 4; m_pv = '0;
    for (int i = 0; i < MR; i++) m_base[i] = i * 20;
    run(0, 0);
    // RIGH P=2 R=5 atl=4
    m_mode = 3'd3; m_pv = 64'h0123_4567_89AB_CDEF;
    for (int i = 0; i < MR; i++) m_base[i] = 112 + i * 20;
    run(0, 0);
    // BOTH P=1 R=3 atl=4, all-ones pad
    m_mode = 3'd4; m_p = 1; m_r = 3; m_atl = 4; m_pv = '1;
    for (int i = 0; i < MR; i++) m_base[i] = i * 24;
    run(0, 0);
    // LEFT P=3 R=7 atl=2, address wrap from 2046
    m_mode = 3'd1; m_p = 3; m_r = 7; m_atl = 2; m_pv = 64'hA5A5_0000_FFFF_1234;
    m_base[0] = 2046;
    for (int i = 1; i < MR; i++) m_base[i] = 2040 + i;
    run(0, 0);
    // FSLD behaves as LEFT
    m_mode = 3'd7; m_p = 2; m_r = 2; m_atl = 3;
    run(0, 0);
    // NORMAL and P=0: no writes, start spammed during busy/DONE
    m_mode = 3'd2; m_p = 2; m_r = 3; m_atl = 4;
    run(0, 1);
    m_mode = 3'd1; m_p = 0;
    run(0, 1);
    // Start spam on a writing run
    m_mode = 3'd4; m_p = 2; m_r = 2; m_atl = 2;
    run(0, 1);
    // Reset in cycle 10 of a LEFT run, then a full rerun
    m_mode = 3'd1; m_p = 2; m_r = 5; m_atl = 4; m_pv = 64'hDEAD_BEEF;
    for (int i = 0; i < MR; i++) m_base[i] = i * 20;
    run(10, 0);
    run(0, 0);

    for (int t = 0; t < 25; t++) begin
      m_mode = 3'(modes[$urandom_range(0, 7)]);
      m_p    = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3));
      m_r    = $urandom_range(0, 7);
      m_atl  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      for (int i = 0; i < MR; i++) m_base[i] = $urandom_range(0, 2047);
      m_pv   = {$urandom, $urandom};
      run(0, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
